// File: rtl/mux32_pkg.sv
// Shared constants and types for the 32-to-1 registered word multiplexer.
package mux32_pkg;

  localparam int MUX32_NUM_IN = 32;
  localparam int MUX32_SEL_W  = 5;

  typedef logic [MUX32_SEL_W-1:0] mux32_sel_t;

endpackage : mux32_pkg

// File: rtl/mux32_reg.sv
// 32-to-1 word multiplexer with a registered output (one cycle latency).
// Optional MUX32_REG_COMB_OUT_EN adds an unregistered out_comb = in[sel].
module mux32_reg
  import mux32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  input  logic [WIDTH-1:0] in16,
  input  logic [WIDTH-1:0] in17,
  input  logic [WIDTH-1:0] in18,
  input  logic [WIDTH-1:0] in19,
  input  logic [WIDTH-1:0] in20,
  input  logic [WIDTH-1:0] in21,
  input  logic [WIDTH-1:0] in22,
  input  logic [WIDTH-1:0] in23,
  input  logic [WIDTH-1:0] in24,
  input  logic [WIDTH-1:0] in25,
  input  logic [WIDTH-1:0] in26,
  input  logic [WIDTH-1:0] in27,
  input  logic [WIDTH-1:0] in28,
  input  logic [WIDTH-1:0] in29,
  input  logic [WIDTH-1:0] in30,
  input  logic [WIDTH-1:0] in31,
  input  logic [4:0]       sel,
`ifdef MUX32_REG_COMB_OUT_EN
  output logic [WIDTH-1:0] out_comb,
  output logic [WIDTH-1:0] out
`else
  output logic [WIDTH-1:0] out
`endif
);

  logic [WIDTH-1:0] w_in [MUX32_NUM_IN];
  mux32_sel_t       w_sel;
  logic [WIDTH-1:0] w_sel_word;
  logic [WIDTH-1:0] r_out;

  assign w_in[0]  = in0;
  assign w_in[1]  = in1;
  assign w_in[2]  = in2;
  assign w_in[3]  = in3;
  assign w_in[4]  = in4;
  assign w_in[5]  = in5;
  assign w_in[6]  = in6;
  assign w_in[7]  = in7;
  assign w_in[8]  = in8;
  assign w_in[9]  = in9;
  assign w_in[10] = in10;
  assign w_in[11] = in11;
  assign w_in[12] = in12;
  assign w_in[13] = in13;
  assign w_in[14] = in14;
  assign w_in[15] = in15;
  assign w_in[16] = in16;
  assign w_in[17] = in17;
  assign w_in[18] = in18;
  assign w_in[19] = in19;
  assign w_in[20] = in20;
  assign w_in[21] = in21;
  assign w_in[22] = in22;
  assign w_in[23] = in23;
  assign w_in[24] = in24;
  assign w_in[25] = in25;
  assign w_in[26] = in26;
  assign w_in[27] = in27;
  assign w_in[28] = in28;
  assign w_in[29] = in29;
  assign w_in[30] = in30;
  assign w_in[31] = in31;

  // Full 5-bit decode: every code addresses a word, so no default path exists.
  assign w_sel      = sel;
  assign w_sel_word = w_in[w_sel];

  // Output register; async reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= {WIDTH{1'b0}};
    end else begin
      r_out <= w_sel_word;
    end
  end

  assign out = r_out;

`ifdef MUX32_REG_COMB_OUT_EN
  assign out_comb = w_sel_word;
`endif

endmodule : mux32_reg

// File: tb/tb_mux32_reg.sv
// Directed and random self-checking bench for mux32_reg.
module tb_mux32_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] tb_in [32];
  logic [4:0]  sel;
  logic [31:0] out;
  logic [31:0] exp_out;
  int          compared;
  int          mismatched;
`ifdef MUX32_REG_COMB_OUT_EN
  logic [31:0] out_comb;
`endif

  mux32_reg #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in0 (tb_in[0]),  .in1 (tb_in[1]),  .in2 (tb_in[2]),  .in3 (tb_in[3]),
    .in4 (tb_in[4]),  .in5 (tb_in[5]),  .in6 (tb_in[6]),  .in7 (tb_in[7]),
    .in8 (tb_in[8]),  .in9 (tb_in[9]),  .in10(tb_in[10]), .in11(tb_in[11]),
    .in12(tb_in[12]), .in13(tb_in[13]), .in14(tb_in[14]), .in15(tb_in[15]),
    .in16(tb_in[16]), .in17(tb_in[17]), .in18(tb_in[18]), .in19(tb_in[19]),
    .in20(tb_in[20]), .in21(tb_in[21]), .in22(tb_in[22]), .in23(tb_in[23]),
    .in24(tb_in[24]), .in25(tb_in[25]), .in26(tb_in[26]), .in27(tb_in[27]),
    .in28(tb_in[28]), .in29(tb_in[29]), .in30(tb_in[30]), .in31(tb_in[31]),
    .sel  (sel),
`ifdef MUX32_REG_COMB_OUT_EN
    .out_comb(out_comb),
`endif
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Capture the expected word from current inputs, clock once, compare after the edge.
  task automatic step_check(input string tag);
    exp_out = tb_in[sel];
`ifdef MUX32_REG_COMB_OUT_EN
    check({tag, "_comb"}, out_comb, exp_out);
`endif
    @(posedge clk);
    #1;
    check(tag, out, exp_out);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    sel        = 5'd5;
    for (int k = 0; k < 32; k++) tb_in[k] = 32'(k);

    // Reset held across edges: out must stay zero.
    #1;
    check("reset_initial", out, 32'h0000_0000);
    @(posedge clk); #1;
    check("reset_after_edge", out, 32'h0000_0000);
`ifdef MUX32_REG_COMB_OUT_EN
    check("comb_in_reset", out_comb, 32'h0000_0005);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Sequential sweep: out equals the previous cycle's sel.
    for (int s = 0; s <= 8; s++) begin
      sel = 5'(s);
      step_check("sweep");
    end
    check("sweep_last_value", out, 32'h0000_0008);

    // Extreme indices with MSB-heavy patterns.
    tb_in[0]  = 32'hA5A5_A5A5;
    tb_in[31] = 32'hFFFF_FFFF;
    sel = 5'd0;
    step_check("sel0");
    check("sel0_const", out, 32'hA5A5_A5A5);
    sel = 5'd31;
    step_check("sel31");
    check("sel31_const", out, 32'hFFFF_FFFF);

    // Data change under fixed sel; other inputs must not disturb out.
    sel = 5'd7;
    tb_in[7] = 32'h0000_0007;
    step_check("fixed_sel_7");
    tb_in[7] = 32'hDEAD_BEEF;
    step_check("fixed_sel_beef");
    check("fixed_sel_beef_const", out, 32'hDEAD_BEEF);
    tb_in[6] = 32'h1111_1111;
    tb_in[8] = 32'h2222_2222;
    @(posedge clk); #1;
    check("other_inputs_ignored", out, 32'hDEAD_BEEF);

    // Simultaneous sel and data change.
    sel = 5'd9;
    tb_in[9] = 32'h1234_5678;
    step_check("sel_and_data");
    check("sel_and_data_const", out, 32'h1234_5678);

    // Random regression.
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 32; k++) tb_in[k] = $urandom();
      sel = 5'($urandom_range(0, 31));
      step_check("random");
    end

    // Mid-run async reset clears out without a clock edge.
    tb_in[3] = 32'hCAFE_F00D;
    sel = 5'd3;
    @(posedge clk); #1;
    check("pre_reset_value", out, 32'hCAFE_F00D);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", out, 32'h0000_0000);
`ifdef MUX32_REG_COMB_OUT_EN
    check("comb_during_reset", out_comb, 32'hCAFE_F00D);
`endif
    @(posedge clk); #1;
    check("async_reset_held", out, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    step_check("after_reset_release");
    check("after_reset_const", out, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mux32_reg
